// File: rtl/calc_muldiv_sequencer.sv
// Iterative unsigned multiply/divide engine: W-cycle shift-add multiply or
// restoring divide on one shared adder/subtractor, one-hot IDLE/RUN/DONE sequencer.
module calc_muldiv_sequencer #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic [W-1:0] Rem,
  output logic         Flag,
  output logic         QI,
  output logic         QRun,
  output logic         QDone
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t         state_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   result_r;
  logic [W-1:0]   rem_r;
  logic           flag_r;
  logic           op_r;
  logic [W-1:0]   b_r;
  logic [W:0]     acc_r;   // multiply hi accumulator / divide partial remainder
  logic [W-1:0]   low_r;   // multiply lo register / divide quotient
  logic [CW-1:0]  cnt_r;

  logic [W:0]     add_a_s;
  logic [W:0]     add_b_s;
  logic [W+1:0]   sum_s;
  logic           take_s;
  logic [W:0]     acc_nxt_s;
  logic [W-1:0]   low_nxt_s;

  // Single adder/subtractor; bit W+1 of a subtraction is the borrow.
  function automatic logic [W+1:0] addsub(input logic [W:0] x, input logic [W:0] y,
                                          input logic sub);
    logic [W+1:0] ye;
    ye = sub ? ~{1'b0, y} : {1'b0, y};
    return {1'b0, x} + ye + {{(W+1){1'b0}}, sub};
  endfunction

  // One iteration step of the active operation.
  always_comb begin
    add_a_s   = '0;
    add_b_s   = '0;
    take_s    = 1'b0;
    acc_nxt_s = acc_r;
    low_nxt_s = low_r;
    if (op_r) begin
      add_a_s   = {acc_r[W-1:0], low_r[W-1]};
      add_b_s   = {1'b0, b_r};
      sum_s     = addsub(add_a_s, add_b_s, 1'b1);
      take_s    = ~sum_s[W+1];
      acc_nxt_s = take_s ? sum_s[W:0] : add_a_s;
      low_nxt_s = {low_r[W-2:0], take_s};
    end else begin
      add_a_s   = acc_r;
      add_b_s   = low_r[0] ? {1'b0, b_r} : '0;
      sum_s     = addsub(add_a_s, add_b_s, 1'b0);
      acc_nxt_s = {1'b0, sum_s[W:1]};
      low_nxt_s = {sum_s[0], low_r[W-1:1]};
    end
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      rem_r    <= '0;
      flag_r   <= 1'b0;
      op_r     <= 1'b0;
      b_r      <= '0;
      acc_r    <= '0;
      low_r    <= '0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            op_r  <= Op;
            b_r   <= B;
            acc_r <= '0;
            low_r <= A;
            cnt_r <= '0;
            busy_r <= 1'b1;
            if (Op && (B == '0)) begin
              state_r  <= S_DONE;
              done_r   <= 1'b1;
              result_r <= '1;
              rem_r    <= A;
              flag_r   <= 1'b1;
            end else begin
              state_r <= S_RUN;
              flag_r  <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_r <= acc_nxt_s;
          low_r <= low_nxt_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(W - 1)) begin
            state_r  <= S_DONE;
            done_r   <= 1'b1;
            result_r <= low_nxt_s;
            rem_r    <= op_r ? acc_nxt_s[W-1:0] : '0;
            flag_r   <= op_r ? 1'b0 : |acc_nxt_s[W-1:0];
          end else begin
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Result = result_r;
  assign Rem    = rem_r;
  assign Flag   = flag_r;
  assign QI     = state_r[0];
  assign QRun   = state_r[1];
  assign QDone  = state_r[2];

endmodule

// File: doc/calc_muldiv_sequencer.md
# calc_muldiv_sequencer

Iterative multiply/divide engine and sequencer for the simple calculator datapath. The calculator control unit uses it for its MUL and DIV operations. The control unit presents operands A and B with an opcode and pulses Start. The block then runs a fixed W-cycle shift-add multiply or restoring divide on one shared adder/subtractor. It returns quotient/product, remainder and an error flag with a one-cycle Done pulse. Results hold until the next accepted Start, so the calculator's DONE state can display them.

## Interface

Parameters:
- W, 16, operand/result width; also the iteration count.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- Op  in  1  0 = multiply, 1 = divide.
- A  in  W  multiplicand / dividend.
- B  in  W  multiplier / divisor.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse, result valid.
- Result  out  W  low W bits of product, or quotient.
- Rem  out  W  divide remainder; 0 after multiply.
- Flag  out  1  multiply overflow (upper W product bits nonzero) or divide-by-zero.
- QI, QRun, QDone  out  1 each  one-hot state outputs.

## Operation

- State register is one-hot {IDLE, RUN, DONE}. QI/QRun/QDone are driven directly from it.
- IDLE: when Start = 1:
  - Latch A, B and Op into internal registers.
  - Clear the iteration counter.
  - Divide with B == 0: go to DONE without running. Load Result = all-ones, Rem = A, Flag = 1.
  - Otherwise clear Flag and go to RUN.
  - When Start = 0, stay in IDLE with outputs unchanged.
- RUN, multiply (W+1-bit hi accumulator, W-bit lo register):
  - Init hi = 0, lo = A latched.
  - Each cycle: if lo[0] is set, hi += B latched (carry kept in bit W).
  - Then shift {hi, lo} right by one.
- RUN, divide (W+1-bit partial remainder r, W-bit quotient q):
  - Init r = 0, q = A latched.
  - Each cycle: r = {r[W-1:0], q[W-1]}; q = q << 1.
  - If r ≥ B latched: r = r − B, q[0] = 1.
- Counter: increments each RUN cycle. At count W−1, transition to DONE and load outputs:
  - Multiply: Result = lo, Rem = 0, Flag = |hi[W-1:0].
  - Divide: Result = q, Rem = r[W-1:0], Flag = 0.
- DONE: Done = 1 for exactly this cycle, then unconditionally go to IDLE.
- Result, Rem and Flag hold their values until the next accepted Start, or Reset.
- Start while Busy = 1 (RUN or DONE) is ignored and not queued. Operand or Op changes during RUN have no effect.
- Arithmetic is unsigned only. Nothing is ever written back to the A/B inputs.

## Timing

- Reset (synchronous) puts the state in IDLE. Busy, Done, Result, Rem, Flag and the counter become 0; QI = 1, QRun = QDone = 0.
- Reset during RUN or DONE aborts the operation. No Done pulse is produced, and outputs are 0 on the cycle after the Reset edge.
- Normal latency:
  - Start sampled at edge 0.
  - RUN occupies cycles 1..W.
  - Done = 1 in cycle W+1 (17 cycles after Start for W = 16).
  - Busy is high for cycles 1..W+1.
- Divide-by-zero latency: Done = 1 in cycle 1; Busy is high for cycle 1 only.
- Minimum Start-to-Start spacing is W+2 cycles, because Start is accepted again in the first IDLE cycle after DONE.
- Result/Rem/Flag update on the same edge that enters DONE, so they are valid whenever Done = 1.
- Reset and Start asserted together: Reset wins and Start is dropped.

## Test plan

- Multiply: A=300, B=200, Op=0, pulse Start → Done exactly 17 cycles later; Result=60000, Rem=0, Flag=0; Busy high for 17 cycles.
- Multiply overflow: A=300, B=300 → Result=24464 (0x5F90), Flag=1. Then A=65535, B=65535 → Result=1, Flag=1.
- Divide: A=1000, B=7, Op=1 → Result=142, Rem=6, Flag=0, Done at cycle 17. Then A=5, B=9 → Result=0, Rem=5.
- Divide by zero: A=5, B=0, Op=1 → Done in cycle 1; Result=0xFFFF, Rem=5, Flag=1; Busy high for one cycle only.
- Start while busy:
  - Start mul 300×200, then re-pulse Start with A=1, B=1 at cycles 5 and 17.
  - Required: both re-pulses ignored, a single Done, Result=60000.
  - Start at cycle 18 is accepted.
- Reset mid-run: Reset at cycle 8 of a divide → next cycle QI=1, Busy=0, Result=Rem=Flag=0, and no Done pulse. A fresh 1000/7 then completes normally with 142 r 6.
